// File: rtl/silu_lut_sequencer.sv
// silu_lut_sequencer: streams one latched activation vector through LUT_LANES
// shared 4-bit SiLU lookup tables. Each PROCESS cycle handles LUT_LANES elements.
// The finished vector is presented on a valid/ready output port.
//
// Build option: define SILU_SEQ_LUT_REG_EN to add one register stage between
// the LUT outputs and the output buffer. PROCESS then takes one extra cycle to
// drain that register. Without the macro, LUT results go straight into the
// output buffer.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Valid never depends on ready. The data stays
// stable while valid is high and ready is low. data_in_0_ready is a pure
// function of the state and data_out_0_ready. It never looks at data_in_0_valid.
//
// State is kept in the internal signal `state` so checkers can bind to it:
// 0 = IDLE, 1 = PROCESS, 2 = OUTPUT.

// 4-bit SiLU lookup, Q2.2 two's complement in and out, rounded to nearest
module silu_lut_4_2 (
  input  logic [3:0] data_in,
  output logic [3:0] data_out
);

  // Table of round(silu(x) * 4) for x = code / 4
  always_comb begin
    data_out = 4'd0;
    case (data_in)
      4'd0:  data_out = 4'd0;   //  0.00 ->  0.00
      4'd1:  data_out = 4'd1;   //  0.25 ->  0.14
      4'd2:  data_out = 4'd1;   //  0.50 ->  0.31
      4'd3:  data_out = 4'd2;   //  0.75 ->  0.51
      4'd4:  data_out = 4'd3;   //  1.00 ->  0.73
      4'd5:  data_out = 4'd4;   //  1.25 ->  0.97
      4'd6:  data_out = 4'd5;   //  1.50 ->  1.23
      4'd7:  data_out = 4'd6;   //  1.75 ->  1.49
      4'd8:  data_out = 4'd15;  // -2.00 -> -0.24
      4'd9:  data_out = 4'd15;  // -1.75 -> -0.26
      4'd10: data_out = 4'd15;  // -1.50 -> -0.27
      4'd11: data_out = 4'd15;  // -1.25 -> -0.28
      4'd12: data_out = 4'd15;  // -1.00 -> -0.27
      4'd13: data_out = 4'd15;  // -0.75 -> -0.24
      4'd14: data_out = 4'd15;  // -0.50 -> -0.19
      4'd15: data_out = 4'd0;   // -0.25 -> -0.11
      default: data_out = 4'd0;
    endcase
  end

endmodule

module silu_lut_sequencer #(
  parameter int DATA_IN_0_PRECISION_0       = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int LUT_LANES                   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [4*DATA_IN_0_TENSOR_SIZE_DIM_0-1:0] data_in_0,
  input  logic                                   data_in_0_valid,
  output logic                                   data_in_0_ready,
  output logic [4*DATA_IN_0_TENSOR_SIZE_DIM_0-1:0] data_out_0,
  output logic                                   data_out_0_valid,
  input  logic                                   data_out_0_ready,
  output logic                                   busy
);

  localparam int SIZE  = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int W     = 4 * SIZE;
  localparam int BEATS = SIZE / LUT_LANES;
  localparam int BW    = $clog2(BEATS) + 1;

`ifdef SILU_SEQ_LUT_REG_EN
  // One extra PROCESS cycle drains the LUT output register
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS);
`else
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
`endif

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PROCESS = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;

  // Reject configurations the LUT and the beat slicing cannot handle
  if (DATA_IN_0_PRECISION_0 != 4) begin : g_bad_precision
    $error("silu_lut_sequencer: DATA_IN_0_PRECISION_0 must be 4");
  end
  if ((LUT_LANES < 1) || (SIZE % LUT_LANES != 0)) begin : g_bad_lanes
    $error("silu_lut_sequencer: SIZE must be a multiple of LUT_LANES");
  end

  logic [1:0]    state;
  logic [BW-1:0] beat;
  logic [W-1:0]  in_buf;
  logic [W-1:0]  out_buf;
  logic          accept;

  logic [3:0]    lut_in  [LUT_LANES];
  logic [3:0]    lut_out [LUT_LANES];

  // Output buffer write port, fed either directly by the LUTs or by the register
  logic          wr_en;
  logic [BW-1:0] wr_beat;
  logic [3:0]    wr_data [LUT_LANES];

  assign accept           = data_in_0_valid & data_in_0_ready;
  assign data_in_0_ready  = (state == IDLE) | ((state == OUTPUT) & data_out_0_ready);
  assign data_out_0_valid = (state == OUTPUT);
  assign data_out_0       = out_buf;
  assign busy             = (state != IDLE);

  // Select this beat's slice of the input buffer for each lane
  always_comb begin
    for (int j = 0; j < LUT_LANES; j++) begin
      lut_in[j] = 4'd0;
      for (int b = 0; b < BEATS; b++) begin
        if (beat == BW'(b)) begin
          lut_in[j] = in_buf[(b*LUT_LANES+j)*4 +: 4];
        end
      end
    end
  end

  for (genvar g = 0; g < LUT_LANES; g++) begin : g_lane
    silu_lut_4_2 u_lut (
      .data_in  (lut_in[g]),
      .data_out (lut_out[g])
    );
  end

`ifdef SILU_SEQ_LUT_REG_EN
  logic          q_valid;
  logic [BW-1:0] q_beat;
  logic [3:0]    lut_q [LUT_LANES];

  // Register LUT results with the beat they belong to; the drain beat loads nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_beat  <= '0;
      for (int j = 0; j < LUT_LANES; j++) lut_q[j] <= 4'd0;
    end else begin
      q_valid <= (state == PROCESS) && (beat != LAST_BEAT);
      q_beat  <= beat;
      for (int j = 0; j < LUT_LANES; j++) lut_q[j] <= lut_out[j];
    end
  end

  // Buffer writes come from the register stage
  always_comb begin
    wr_en   = (state == PROCESS) && q_valid;
    wr_beat = q_beat;
    for (int j = 0; j < LUT_LANES; j++) wr_data[j] = lut_q[j];
  end
`else
  // Buffer writes come straight from the LUTs
  always_comb begin
    wr_en   = (state == PROCESS);
    wr_beat = beat;
    for (int j = 0; j < LUT_LANES; j++) wr_data[j] = lut_out[j];
  end
`endif

  // Control FSM and beat counter; the counter wraps to 0 whenever PROCESS ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= PROCESS;
            beat  <= '0;
          end
        end
        PROCESS: begin
          if (beat == LAST_BEAT) begin
            state <= OUTPUT;
            beat  <= '0;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        OUTPUT: begin
          if (data_out_0_ready) begin
            // A vector offered during the output handshake is taken with no bubble
            state <= data_in_0_valid ? PROCESS : IDLE;
            beat  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  // The input buffer is loaded only on accept, so the slice being processed never moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_buf <= '0;
    end else if (accept) begin
      in_buf <= data_in_0;
    end
  end

  // The output buffer is written only during PROCESS, so it is frozen in OUTPUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_buf <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BEATS; b++) begin
        if (wr_beat == BW'(b)) begin
          for (int j = 0; j < LUT_LANES; j++) begin
            out_buf[(b*LUT_LANES+j)*4 +: 4] <= wr_data[j];
          end
        end
      end
    end
  end

endmodule
